// File: rtl/debug_bp_engine.sv
`default_nettype none
// ============================================================================
// Module      : debug_bp_engine
// Description : Breakpoint engine between a target core and its code ROM.
//               NUM_BP address breakpoints (each with a skip counter) plus a
//               single-step mode. A match either arms the engine (no
//               execution that cycle) or triggers an immediate halt-check.
//               While halted, the opcode-ready handshake to the target is
//               withheld. The debugger can also divert the bus and force an
//               opcode.
// Ports       : sysclk/sysreset  - clock, async active-high reset
//               rom_code_*       - opcode and valid from the code ROM
//               tg_*  (in)       - target fetch address, EXR load, exec strobe
//               tg_*  (out)      - opcode, valid and reset to the target
//               cfg_*            - register port (comb read, one write/cycle)
//               bp_irq           - one-cycle pulse on entry to HALTED
// Revision    : 1.0 - initial release
// ============================================================================
module debug_bp_engine #(
    parameter int NUM_BP = 4,
    parameter int ADDR_W = 16,
    parameter int SKIP_W = 8
) (
    input  logic              sysclk,
    input  logic              sysreset,
    input  logic [15:0]       rom_code_in,
    input  logic              rom_code_ready,
    input  logic [ADDR_W-1:0] tg_code_addr,
    input  logic              tg_loading_exr,
    input  logic              tg_enable_exec,
    output logic [15:0]       tg_code_in,
    output logic              tg_code_ready,
    output logic              tg_reset,
    input  logic [4:0]        cfg_addr,
    input  logic [15:0]       cfg_wdata,
    input  logic              cfg_we,
    output logic [15:0]       cfg_rdata,
    output logic              bp_irq
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_ARMED  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t              state;
    logic [3:0]          bus_ctrl;
    logic [15:0]         force_opcode;
    logic [15:0]         exr_shadow;
    logic [ADDR_W-1:0]   hit_addr;
    logic [2:0]          hit_chan;
    logic                hit_step;
    logic [ADDR_W-1:0]   bp_addr [NUM_BP];
    logic [SKIP_W-1:0]   skip_cnt [NUM_BP];
    logic [NUM_BP-1:0]   bp_en;
    logic [NUM_BP-1:0]   armed_mask;
    logic                armed_step;

    // Register-port decode for the per-channel window (0x10..0x1F).
    logic [2:0]          bp_idx;
    logic                bp_sel;
    logic                bp_addr_we;
    logic                bp_cfg_we;
    logic                resume_we;

    assign bp_idx     = cfg_addr[3:1];
    assign bp_sel     = cfg_we && cfg_addr[4] && (int'(bp_idx) < NUM_BP);
    assign bp_addr_we = bp_sel && !cfg_addr[0];
    assign bp_cfg_we  = bp_sel && cfg_addr[0];
    assign resume_we  = cfg_we && (cfg_addr == 5'h02) && cfg_wdata[0];

    // Candidate set: live address matches, plus whatever was latched while
    // armed. Step only decides the outcome when no channel is a candidate.
    logic [NUM_BP-1:0]   match;
    logic [NUM_BP-1:0]   cand;
    logic                cand_step;
    logic                any_cand;
    logic                win_found;
    logic [2:0]          win_idx;
    logic [SKIP_W-1:0]   win_skip;

    always_comb begin
        match     = '0;
        win_found = 1'b0;
        win_idx   = '0;
        win_skip  = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            match[i] = bp_en[i] && (tg_code_addr == bp_addr[i]);
        end
        cand      = match | ((state == ST_ARMED) ? armed_mask : '0);
        cand_step = bus_ctrl[3] || ((state == ST_ARMED) && armed_step);
        any_cand  = (cand != '0) || cand_step;
        // Descending scan so the lowest index is the last one written.
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_found = 1'b1;
                win_idx   = 3'(i);
                win_skip  = skip_cnt[i];
            end
        end
    end

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            state        <= ST_RUN;
            bus_ctrl     <= '0;
            force_opcode <= '0;
            exr_shadow   <= '0;
            hit_addr     <= '0;
            hit_chan     <= '0;
            hit_step     <= 1'b0;
            bp_en        <= '0;
            armed_mask   <= '0;
            armed_step   <= 1'b0;
            bp_irq       <= 1'b0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_addr[i]  <= '0;
                skip_cnt[i] <= '0;
            end
        end else begin
            bp_irq <= 1'b0;

            if (tg_loading_exr && !bus_ctrl[2]) begin
                exr_shadow <= rom_code_in;
            end

            if (cfg_we && (cfg_addr == 5'h00)) bus_ctrl     <= cfg_wdata[3:0];
            if (cfg_we && (cfg_addr == 5'h01)) force_opcode <= cfg_wdata;

            for (int i = 0; i < NUM_BP; i++) begin
                if (bp_addr_we && (bp_idx == 3'(i))) begin
                    bp_addr[i] <= ADDR_W'(cfg_wdata);
                end
                if (bp_cfg_we && (bp_idx == 3'(i))) begin
                    bp_en[i]    <= cfg_wdata[0];
                    skip_cnt[i] <= cfg_wdata[8 +: SKIP_W];
                end
            end

            // Any register write in a cycle masks that cycle's match, so the
            // debugger can reconfigure without racing the target.
            case (state)
                ST_RUN, ST_ARMED: begin
                    if (!cfg_we && any_cand) begin
                        if (tg_enable_exec) begin
                            if (win_found && (win_skip != '0)) begin
                                for (int i = 0; i < NUM_BP; i++) begin
                                    if (win_idx == 3'(i)) begin
                                        skip_cnt[i] <= win_skip - SKIP_W'(1);
                                    end
                                end
                                state <= ST_RUN;
                            end else begin
                                state    <= ST_HALTED;
                                hit_addr <= tg_code_addr;
                                hit_chan <= win_idx;
                                hit_step <= !win_found;
                                bp_irq   <= 1'b1;
                            end
                            armed_mask <= '0;
                            armed_step <= 1'b0;
                        end else begin
                            state      <= ST_ARMED;
                            armed_mask <= cand;
                            armed_step <= cand_step;
                        end
                    end
                end
                ST_HALTED: begin
                    if (resume_we || bp_sel) begin
                        state      <= ST_RUN;
                        armed_mask <= '0;
                        armed_step <= 1'b0;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            5'h00: cfg_rdata = {12'd0, bus_ctrl};
            5'h01: cfg_rdata = force_opcode;
            5'h02: cfg_rdata = {8'd0, hit_step, hit_chan, 2'b00,
                                (state == ST_ARMED), (state == ST_HALTED)};
            5'h03: cfg_rdata = exr_shadow;
            5'h04: cfg_rdata = 16'(hit_addr);
            5'h05: cfg_rdata = 16'(tg_code_addr);
            default: begin
                for (int i = 0; i < NUM_BP; i++) begin
                    if (cfg_addr == 5'(16 + 2 * i)) cfg_rdata = 16'(bp_addr[i]);
                    if (cfg_addr == 5'(17 + 2 * i)) begin
                        cfg_rdata = {8'(skip_cnt[i]), 7'd0, bp_en[i]};
                    end
                end
            end
        endcase
    end

    assign tg_code_ready = bus_ctrl[2] ? bus_ctrl[0]
                                       : (rom_code_ready && (state != ST_HALTED));
    assign tg_code_in    = bus_ctrl[2] ? force_opcode : rom_code_in;
    assign tg_reset      = sysreset || bus_ctrl[1];

endmodule
`default_nettype wire

// File: tb/tb_debug_bp_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_bp_engine
// Description : Self-checking bench for debug_bp_engine: a table of directed
//               vectors, hand-written reset sequences, and a randomized phase
//               compared against a behavioural model of the breakpoint rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_bp_engine;

    localparam int NBP = 4;
    localparam int S_RUN = 0, S_ARMED = 1, S_HALTED = 2;

    logic        sysclk = 1'b0;
    logic        sysreset;
    logic [15:0] rom_code_in;
    logic        rom_code_ready;
    logic [15:0] tg_code_addr;
    logic        tg_loading_exr;
    logic        tg_enable_exec;
    logic [15:0] tg_code_in;
    logic        tg_code_ready;
    logic        tg_reset;
    logic [4:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        cfg_we;
    logic [15:0] cfg_rdata;
    logic        bp_irq;

    int checks   = 0;
    int failures = 0;

    debug_bp_engine #(.NUM_BP(NBP), .ADDR_W(16), .SKIP_W(8)) dut (
        .sysclk         (sysclk),
        .sysreset       (sysreset),
        .rom_code_in    (rom_code_in),
        .rom_code_ready (rom_code_ready),
        .tg_code_addr   (tg_code_addr),
        .tg_loading_exr (tg_loading_exr),
        .tg_enable_exec (tg_enable_exec),
        .tg_code_in     (tg_code_in),
        .tg_code_ready  (tg_code_ready),
        .tg_reset       (tg_reset),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .cfg_we         (cfg_we),
        .cfg_rdata      (cfg_rdata),
        .bp_irq         (bp_irq)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit        we;
        bit [4:0]  addr;
        bit [15:0] wdata;
        bit [15:0] caddr;
        bit        exec;
        bit        load;
        bit [15:0] rom;
        bit [15:0] e_rdata;
        bit        e_ready;
        bit        e_irq;
        bit [15:0] e_code;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit we, input bit [4:0] a, input bit [15:0] wd,
                       input bit [15:0] ca, input bit ex, input bit ld,
                       input bit [15:0] rom, input bit [15:0] er,
                       input bit erdy, input bit eirq, input bit [15:0] ecode);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = wd; v.caddr = ca; v.exec = ex;
        v.load = ld; v.rom = rom; v.e_rdata = er; v.e_ready = erdy;
        v.e_irq = eirq; v.e_code = ecode;
        vecs.push_back(v);
    endtask

    task automatic cyc(input bit we, input bit [4:0] a, input bit [15:0] wd,
                       input bit [15:0] ca, input bit ex);
        cfg_we = we; cfg_addr = a; cfg_wdata = wd;
        tg_code_addr = ca; tg_enable_exec = ex;
        @(posedge sysclk); #1;
    endtask

    // ---------------- behavioural model ----------------
    bit [3:0]  m_bus;
    bit [15:0] m_force, m_exr, m_hit_addr;
    int        m_state, m_hit_chan;
    bit        m_hit_step, m_irq, m_armed_step;
    bit [15:0] m_bpaddr[NBP];
    bit        m_en[NBP];
    bit        m_armed[NBP];
    int        m_skip[NBP];

    task automatic model_reset();
        m_bus = 0; m_force = 0; m_exr = 0; m_hit_addr = 0;
        m_state = S_RUN; m_hit_chan = 0; m_hit_step = 0; m_irq = 0;
        m_armed_step = 0;
        for (int c = 0; c < NBP; c++) begin
            m_bpaddr[c] = 0; m_en[c] = 0; m_armed[c] = 0; m_skip[c] = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs present before it.
    task automatic model_tick();
        int  a;
        int  ch;
        bit  bp_wr;
        bit  stepping;
        int  cands[$];
        a     = int'(cfg_addr);
        ch    = (a - 16) / 2;
        bp_wr = cfg_we && (a >= 16) && (ch < NBP);
        m_irq = 0;
        if (m_state == S_HALTED) begin
            if (cfg_we && ((a == 2 && cfg_wdata[0]) || bp_wr)) begin
                m_state = S_RUN;
                m_armed_step = 0;
                for (int c = 0; c < NBP; c++) m_armed[c] = 0;
            end
        end else if (!cfg_we) begin
            for (int c = 0; c < NBP; c++) begin
                if ((m_en[c] && m_bpaddr[c] == tg_code_addr) ||
                    (m_state == S_ARMED && m_armed[c]))
                    cands.push_back(c);
            end
            stepping = m_bus[3] || (m_state == S_ARMED && m_armed_step);
            if (cands.size() > 0 || stepping) begin
                if (tg_enable_exec) begin
                    if (cands.size() > 0 && m_skip[cands[0]] > 0) begin
                        m_skip[cands[0]] = m_skip[cands[0]] - 1;
                        m_state = S_RUN;
                    end else begin
                        m_state    = S_HALTED;
                        m_hit_addr = tg_code_addr;
                        m_hit_chan = (cands.size() > 0) ? cands[0] : 0;
                        m_hit_step = (cands.size() == 0);
                        m_irq      = 1;
                    end
                    m_armed_step = 0;
                    for (int c = 0; c < NBP; c++) m_armed[c] = 0;
                end else begin
                    m_state = S_ARMED;
                    foreach (cands[k]) m_armed[cands[k]] = 1;
                    m_armed_step = stepping;
                end
            end
        end
        if (tg_loading_exr && !m_bus[2]) m_exr = rom_code_in;
        if (cfg_we) begin
            if (a == 0) m_bus = cfg_wdata[3:0];
            if (a == 1) m_force = cfg_wdata;
            if (bp_wr) begin
                if (a % 2 == 0) m_bpaddr[ch] = cfg_wdata;
                else begin
                    m_en[ch]   = cfg_wdata[0];
                    m_skip[ch] = int'(cfg_wdata[15:8]);
                end
            end
        end
    endtask

    function automatic bit [15:0] model_read(input int a);
        int ch;
        ch = (a - 16) / 2;
        case (a)
            0: return {12'd0, m_bus};
            1: return m_force;
            2: return 16'((m_state == S_HALTED ? 1 : 0) | (m_state == S_ARMED ? 2 : 0) |
                          (m_hit_chan << 4) | (m_hit_step ? 128 : 0));
            3: return m_exr;
            4: return m_hit_addr;
            5: return tg_code_addr;
            default: begin
                if (a >= 16 && ch < NBP) begin
                    if (a % 2 == 0) return m_bpaddr[ch];
                    return 16'((m_skip[ch] << 8) | (m_en[ch] ? 1 : 0));
                end
                return 16'd0;
            end
        endcase
    endfunction

    function automatic bit [15:0] pick_addr();
        case ($urandom_range(0, 4))
            0: return 16'h0040;
            1: return 16'h0041;
            2: return 16'h0100;
            3: return 16'h0200;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic rand_inputs();
        cfg_we    = ($urandom_range(0, 7) == 0);
        cfg_addr  = ($urandom_range(0, 3) == 0) ? 5'd2 : 5'($urandom_range(0, 31));
        cfg_wdata = 16'($urandom);
        if (cfg_addr == 5'd0) cfg_wdata[3] = ($urandom_range(0, 3) == 0);
        if (cfg_addr >= 5'd16 && !cfg_addr[0]) cfg_wdata = pick_addr();
        if (cfg_addr >= 5'd16 && cfg_addr[0]) cfg_wdata[15:8] = 8'($urandom_range(0, 3));
        tg_code_addr   = pick_addr();
        tg_enable_exec = 1'($urandom_range(0, 1));
        tg_loading_exr = 1'($urandom_range(0, 1));
        rom_code_in    = 16'($urandom);
        rom_code_ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        sysreset = 1'b1;
        rom_code_in = 16'h1234; rom_code_ready = 1'b1;
        tg_code_addr = 16'h0; tg_loading_exr = 1'b0; tg_enable_exec = 1'b0;
        cfg_addr = 5'h02; cfg_wdata = 16'h0; cfg_we = 1'b0;
        #1;
        check("rst_tg_reset", tg_reset, 1);
        check("rst_ready",    tg_code_ready, 1);
        check("rst_code_in",  tg_code_in, 16'h1234);
        check("rst_irq",      bp_irq, 0);
        check("rst_status",   cfg_rdata, 0);
        @(posedge sysclk); @(posedge sysclk); #1;
        sysreset = 1'b0;
        #1;
        check("rel_tg_reset", tg_reset, 0);

        //   we  addr   wdata    caddr    ex ld rom      rdata    rdy irq code
        add(1, 5'h10, 16'h0040, 16'h0000, 0, 0, 16'h1234, 16'h0040, 1, 0, 16'h1234);
        add(1, 5'h11, 16'h0001, 16'h0000, 0, 0, 16'h1234, 16'h0001, 1, 0, 16'h1234);
        add(0, 5'h02, 16'h0000, 16'h0040, 0, 0, 16'h1234, 16'h0002, 1, 0, 16'h1234);
        add(0, 5'h02, 16'h0000, 16'h0040, 1, 0, 16'h1234, 16'h0001, 0, 1, 16'h1234);
        add(0, 5'h04, 16'h0000, 16'h0000, 0, 0, 16'h1234, 16'h0040, 0, 0, 16'h1234);
        add(1, 5'h02, 16'h0001, 16'h0000, 0, 0, 16'h1234, 16'h0000, 1, 0, 16'h1234);
        add(1, 5'h12, 16'h0100, 16'h0000, 0, 0, 16'h1234, 16'h0100, 1, 0, 16'h1234);
        add(1, 5'h13, 16'h0201, 16'h0000, 0, 0, 16'h1234, 16'h0201, 1, 0, 16'h1234);
        add(0, 5'h13, 16'h0000, 16'h0100, 1, 0, 16'h1234, 16'h0101, 1, 0, 16'h1234);
        add(0, 5'h13, 16'h0000, 16'h0000, 0, 0, 16'h1234, 16'h0101, 1, 0, 16'h1234);
        add(0, 5'h13, 16'h0000, 16'h0100, 1, 0, 16'h1234, 16'h0001, 1, 0, 16'h1234);
        add(0, 5'h13, 16'h0000, 16'h0000, 0, 0, 16'h1234, 16'h0001, 1, 0, 16'h1234);
        add(0, 5'h02, 16'h0000, 16'h0100, 1, 0, 16'h1234, 16'h0011, 0, 1, 16'h1234);
        add(0, 5'h13, 16'h0000, 16'h0000, 0, 0, 16'h1234, 16'h0001, 0, 0, 16'h1234);
        add(1, 5'h02, 16'h0001, 16'h0000, 0, 0, 16'h1234, 16'h0010, 1, 0, 16'h1234);
        add(1, 5'h10, 16'h0200, 16'h0000, 0, 0, 16'h1234, 16'h0200, 1, 0, 16'h1234);
        add(1, 5'h14, 16'h0200, 16'h0000, 0, 0, 16'h1234, 16'h0200, 1, 0, 16'h1234);
        add(1, 5'h15, 16'h0001, 16'h0000, 0, 0, 16'h1234, 16'h0001, 1, 0, 16'h1234);
        add(0, 5'h02, 16'h0000, 16'h0200, 1, 0, 16'h1234, 16'h0001, 0, 1, 16'h1234);
        add(1, 5'h02, 16'h0001, 16'h0000, 0, 0, 16'h1234, 16'h0000, 1, 0, 16'h1234);
        add(1, 5'h11, 16'h0001, 16'h0200, 1, 0, 16'h1234, 16'h0001, 1, 0, 16'h1234);
        add(0, 5'h02, 16'h0000, 16'h0000, 0, 0, 16'h1234, 16'h0000, 1, 0, 16'h1234);
        add(1, 5'h00, 16'h0008, 16'h0000, 0, 0, 16'h1234, 16'h0008, 1, 0, 16'h1234);
        add(0, 5'h02, 16'h0000, 16'h0333, 0, 0, 16'h1234, 16'h0002, 1, 0, 16'h1234);
        add(0, 5'h02, 16'h0000, 16'h0333, 1, 0, 16'h1234, 16'h0081, 0, 1, 16'h1234);
        add(0, 5'h13, 16'h0000, 16'h0000, 0, 0, 16'h1234, 16'h0001, 0, 0, 16'h1234);
        add(1, 5'h01, 16'hBEEF, 16'h0000, 0, 0, 16'h1234, 16'hBEEF, 0, 0, 16'h1234);
        add(1, 5'h00, 16'h000D, 16'h0000, 0, 0, 16'h1234, 16'h000D, 1, 0, 16'hBEEF);
        add(0, 5'h03, 16'h0000, 16'h0000, 0, 1, 16'h5555, 16'h0000, 1, 0, 16'hBEEF);
        add(1, 5'h00, 16'h0000, 16'h0000, 0, 0, 16'h1234, 16'h0000, 0, 0, 16'h1234);
        add(0, 5'h03, 16'h0000, 16'h0000, 0, 1, 16'h5555, 16'h5555, 0, 0, 16'h5555);

        foreach (vecs[k]) begin
            cfg_we = vecs[k].we; cfg_addr = vecs[k].addr; cfg_wdata = vecs[k].wdata;
            tg_code_addr = vecs[k].caddr; tg_enable_exec = vecs[k].exec;
            tg_loading_exr = vecs[k].load; rom_code_in = vecs[k].rom;
            rom_code_ready = 1'b1;
            @(posedge sysclk); #1;
            check($sformatf("vec%0d_rdata", k), cfg_rdata, vecs[k].e_rdata);
            check($sformatf("vec%0d_ready", k), tg_code_ready, vecs[k].e_ready);
            check($sformatf("vec%0d_irq", k), bp_irq, vecs[k].e_irq);
            check($sformatf("vec%0d_code", k), tg_code_in, vecs[k].e_code);
        end

        // Reset while halted: asynchronous, outputs at reset values at once.
        cfg_we = 0; cfg_addr = 5'h02; tg_loading_exr = 0; tg_enable_exec = 0;
        rom_code_ready = 1'b0; rom_code_in = 16'hA5A5;
        #2 sysreset = 1'b1;
        #1;
        check("halt_rst_tg_reset", tg_reset, 1);
        check("halt_rst_ready", tg_code_ready, 0);
        check("halt_rst_code", tg_code_in, 16'hA5A5);
        check("halt_rst_status", cfg_rdata, 0);
        check("halt_rst_irq", bp_irq, 0);
        rom_code_ready = 1'b1;
        #1;
        check("halt_rst_ready_follow", tg_code_ready, 1);
        @(posedge sysclk); #1;
        sysreset = 1'b0;
        cyc(0, 5'h11, 16'h0, 16'h0, 0);
        check("post_rst_bpcfg0", cfg_rdata, 0);
        check("post_rst_tg_reset", tg_reset, 0);

        // Reset while armed: back to RUN, armed state forgotten.
        cyc(1, 5'h10, 16'h0040, 16'h0, 0);
        cyc(1, 5'h11, 16'h0001, 16'h0, 0);
        cyc(0, 5'h02, 16'h0, 16'h0040, 0);
        check("armed_status", cfg_rdata, 16'h0002);
        #2 sysreset = 1'b1;
        #1;
        check("armed_rst_status", cfg_rdata, 0);
        @(posedge sysclk); #1;
        sysreset = 1'b0;
        cyc(0, 5'h02, 16'h0, 16'h0, 1);
        check("armed_rst_no_halt", cfg_rdata, 0);
        check("armed_rst_no_irq", bp_irq, 0);

        // Randomized phase against the behavioural model.
        #2 sysreset = 1'b1;
        @(posedge sysclk); #1;
        sysreset = 1'b0;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            @(posedge sysclk);
            model_tick();
            #1;
            check($sformatf("rnd%0d_rdata@%0h", n, cfg_addr), cfg_rdata, model_read(int'(cfg_addr)));
            check($sformatf("rnd%0d_ready", n), tg_code_ready,
                  m_bus[2] ? m_bus[0] : (rom_code_ready && m_state != S_HALTED));
            check($sformatf("rnd%0d_code", n), tg_code_in, m_bus[2] ? m_force : rom_code_in);
            check($sformatf("rnd%0d_tg_reset", n), tg_reset, m_bus[1]);
            check($sformatf("rnd%0d_irq", n), bp_irq, m_irq);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
